// File: rtl/console_uart_tx.sv
// console_uart_tx: 8N1 UART transmitter fed from the Wrapper CONSOLE_OUT stream.
// A small circular byte FIFO absorbs console writes; the serial FSM drains it
// with no idle gap between frames while data is queued.
module console_uart_tx #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLK_undiv,
  input  logic       RESET,
  input  logic [7:0] CONSOLE_OUT,
  input  logic       CONSOLE_OUT_valid,
  output logic       CONSOLE_OUT_ready,
  output logic       TX,
  output logic       BUSY
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLK_DIV);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_nz;
  logic          w_baud_wrap;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    w_bit_next;
  logic [7:0]    w_shift_next;
  logic          w_tx_next;

  assign w_ready     = (r_count < DEPTH_C);
  assign w_push      = CONSOLE_OUT_valid && w_ready;
  assign w_fifo_nz   = (r_count != '0);
  assign w_baud_wrap = (r_baud == BAUD_MAX);

  assign CONSOLE_OUT_ready = w_ready;
  assign TX                = r_tx;
  assign BUSY              = (r_state != ST_IDLE) || w_fifo_nz;

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge CLK_undiv) begin
    if (w_push) begin
      r_mem[r_wptr] <= CONSOLE_OUT;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge CLK_undiv) begin
    if (RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK_undiv) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and pop decision
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_nz) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_baud_wrap) begin
          w_state_next = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_baud_wrap && (r_bit == 3'd7)) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_baud_wrap) begin
          if (w_fifo_nz) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: next counter/shift values and the next registered line level
  always_comb begin
    w_baud_next  = r_baud + BW'(1);
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    if ((r_state == ST_IDLE) || w_pop || w_baud_wrap) begin
      w_baud_next = '0;
    end
    if (w_pop) begin
      w_bit_next   = '0;
      w_shift_next = r_mem[r_rptr];
    end else if ((r_state == ST_DATA) && w_baud_wrap) begin
      w_bit_next   = r_bit + 3'd1;
      w_shift_next = {1'b0, r_shift[7:1]};
    end
    // TX is computed from the next state so the line changes on the same
    // edge as the state, keeping the output a plain flop
    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = w_shift_next[0];
      default:  w_tx_next = 1'b1;
    endcase
  end

  // Baud counter, bit counter, shift register and TX flop
  always_ff @(posedge CLK_undiv) begin
    if (RESET) begin
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: directed bench for console_uart_tx with a byte scoreboard
// and a free-running serial-line decoder.
module tb_console_uart_tx;

  localparam int CLK_DIV = 10;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] CONSOLE_OUT = 8'h00;
  logic       CONSOLE_OUT_valid = 1'b0;
  logic       CONSOLE_OUT_ready;
  logic       TX;
  logic       BUSY;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  logic [7:0] sb [$];

  console_uart_tx #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_DEPTH(4)
  ) dut (
    .CLK_undiv        (clk),
    .RESET            (RESET),
    .CONSOLE_OUT      (CONSOLE_OUT),
    .CONSOLE_OUT_valid(CONSOLE_OUT_valid),
    .CONSOLE_OUT_ready(CONSOLE_OUT_ready),
    .TX               (TX),
    .BUSY             (BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serial decoder: frame starts at the first low sample, bits sampled mid-cell
  logic       mon_active = 1'b0;
  int         mon_cnt = 0;
  logic       mon_start_ok = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  logic [31:0] mon_exp;

  always @(negedge clk) begin
    if (RESET) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (TX === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == 5) mon_start_ok = (TX === 1'b0);
      if ((mon_cnt >= 15) && (mon_cnt <= 85) && ((mon_cnt % 10) == 5))
        mon_byte[(mon_cnt / 10) - 1] = TX;
      if (mon_cnt == 95) begin
        mon_active = 1'b0;
        frames++;
        check("start_bit", {31'd0, mon_start_ok}, 32'd1);
        check("stop_bit", {31'd0, TX}, 32'd1);
        mon_exp = (sb.size() != 0) ? {24'd0, sb.pop_front()} : 32'h1DEAD;
        check("frame_data", {24'd0, mon_byte}, mon_exp);
      end
    end
  end

  initial begin
    int bad;
    int e;
    int nxt;
    int acc_edge [6];
    logic rdy;
    logic rdy_after5;
    int frames_before;
    logic [7:0] b;
    logic exp_bit;

    // Reset
    repeat (2) tick();
    RESET = 1'b0;
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_ready", {31'd0, CONSOLE_OUT_ready}, 32'd1);
    check("rst_busy", {31'd0, BUSY}, 32'd0);
    bad = 0;
    repeat (50) begin
      tick();
      if (TX !== 1'b1) bad++;
    end
    check("idle_tx_low_cycles", bad, 0);

    // Single byte 0x41, exact waveform
    b = 8'h41;
    sb.push_back(b);
    CONSOLE_OUT = b;
    CONSOLE_OUT_valid = 1'b1;
    tick();
    CONSOLE_OUT_valid = 1'b0;
    check("single_busy_after_accept", {31'd0, BUSY}, 32'd1);
    check("single_tx_before_start", {31'd0, TX}, 32'd1);
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (j < 10) exp_bit = 1'b0;
      else if (j >= 90) exp_bit = 1'b1;
      else exp_bit = b[(j / 10) - 1];
      if (TX !== exp_bit) bad++;
    end
    check("single_wave_errs", bad, 0);
    check("single_busy_k100", {31'd0, BUSY}, 32'd1);
    tick();
    check("single_busy_k101", {31'd0, BUSY}, 32'd0);
    repeat (5) tick();

    // Burst with backpressure and stall data churn
    for (int i = 0; i < 6; i++) sb.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 6; i++) acc_edge[i] = -1;
    e = 0;
    nxt = 8'h30;
    rdy_after5 = 1'b1;
    CONSOLE_OUT = 8'h30;
    CONSOLE_OUT_valid = 1'b1;
    while ((nxt <= 8'h35) && (e < 300)) begin
      rdy = CONSOLE_OUT_ready;
      tick();
      e++;
      if (rdy) begin
        acc_edge[nxt - 8'h30] = e;
        nxt++;
      end
      if (e == 5) rdy_after5 = CONSOLE_OUT_ready;
      if (nxt > 8'h35) CONSOLE_OUT_valid = 1'b0;
      else if (CONSOLE_OUT_ready) CONSOLE_OUT = 8'(nxt);
      else CONSOLE_OUT = 8'($urandom);
    end
    CONSOLE_OUT_valid = 1'b0;
    check("burst_acc0", acc_edge[0], 1);
    check("burst_acc4", acc_edge[4], 5);
    check("burst_ready_full", {31'd0, rdy_after5}, 32'd0);
    check("burst_acc5", acc_edge[5], 103);
    while (e < 601) begin
      tick();
      e++;
    end
    check("burst_busy_e601", {31'd0, BUSY}, 32'd1);
    tick();
    check("burst_busy_e602", {31'd0, BUSY}, 32'd0);
    check("burst_sb_empty", sb.size(), 0);
    repeat (5) tick();

    // Reset mid-frame
    sb.push_back(8'hFF);
    sb.push_back(8'h00);
    CONSOLE_OUT = 8'hFF;
    CONSOLE_OUT_valid = 1'b1;
    tick();
    CONSOLE_OUT = 8'h00;
    tick();
    CONSOLE_OUT_valid = 1'b0;
    repeat (42) tick();
    RESET = 1'b1;
    tick();
    check("midrst_tx", {31'd0, TX}, 32'd1);
    check("midrst_ready", {31'd0, CONSOLE_OUT_ready}, 32'd1);
    check("midrst_busy", {31'd0, BUSY}, 32'd0);
    RESET = 1'b0;
    sb.delete();
    bad = 0;
    repeat (150) begin
      tick();
      if ((TX !== 1'b1) || (BUSY !== 1'b0)) bad++;
    end
    check("midrst_quiet_errs", bad, 0);
    sb.push_back(8'h55);
    CONSOLE_OUT = 8'h55;
    CONSOLE_OUT_valid = 1'b1;
    tick();
    CONSOLE_OUT_valid = 1'b0;
    repeat (110) tick();
    check("midrst_new_sb_empty", sb.size(), 0);

    // Pointer wrap
    frames_before = frames;
    for (int i = 1; i <= 9; i++) begin
      sb.push_back(8'(i));
      CONSOLE_OUT = 8'(i);
      CONSOLE_OUT_valid = 1'b1;
      tick();
      CONSOLE_OUT_valid = 1'b0;
      repeat (119) tick();
    end
    check("wrap_frames", frames - frames_before, 9);
    check("wrap_sb_empty", sb.size(), 0);
    check("total_frames", frames, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/console_uart_tx.md
# console_uart_tx

Serial transmitter that consumes the Wrapper's CONSOLE_OUT byte stream and drives an 8N1 UART TX line to the board's USB-UART bridge. It sits directly downstream of Wrapper in the top-level shell, in place of the testbench's console sink. A small FIFO decouples the processor's console writes from the slow serial line. Backpressure to the processor is applied through CONSOLE_OUT_ready.

## Interface
Parameters:
- CLK_DIV, 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.
- FIFO_DEPTH, 4: byte FIFO depth. Must be a power of 2 and ≥ 2.

Ports:
- CLK_undiv  in  1  system clock. One clock domain only.
- RESET  in  1  reset, synchronous and active-high.
- CONSOLE_OUT  in  8  byte from Wrapper.
- CONSOLE_OUT_valid  in  1  byte on CONSOLE_OUT is valid.
- CONSOLE_OUT_ready  out  1  FIFO can accept a byte this cycle.
- TX  out  1  serial line. Idle high. Registered.
- BUSY  out  1  a frame is in progress or the FIFO is non-empty.

## Operation
Handshake:
- A byte is accepted on a rising edge where CONSOLE_OUT_valid && CONSOLE_OUT_ready.
- CONSOLE_OUT_ready = (FIFO count < FIFO_DEPTH). It is derived from the registered count only.
- When the FIFO is full, ready is 0 even if a pop occurs in the same cycle.
- Valid asserted without ready: nothing is written and no state changes. The producer holds the data.
- A push and a pop on the same edge leave the count unchanged.

FIFO:
- Circular buffer with read and write pointers of log2(FIFO_DEPTH) bits. Pointers wrap modulo FIFO_DEPTH.
- Separate count register of log2(FIFO_DEPTH)+1 bits.

FSM states: IDLE, START, DATA, STOP.
- IDLE: TX=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter and baud counter, go to START.
- START: TX=0 for CLK_DIV cycles, then go to DATA.
- DATA: send 8 bits, LSB first, each for CLK_DIV cycles. Shift right after each bit. After bit 7, go to STOP.
- STOP: TX=1 for CLK_DIV cycles. At the end of the stop bit:
  - FIFO non-empty: pop and go directly to START. There is no idle gap between frames.
  - FIFO empty: go to IDLE.

Baud counter:
- Counts 0 to CLK_DIV-1, then wraps.
- A bit boundary occurs at the wrap.

BUSY = (state != IDLE) || (count != 0).

Reset:
- Applies from any state: FSM to IDLE, FIFO emptied (pointers and count = 0), counters = 0.
- If a frame is in progress, it is abandoned. TX returns to 1 on the reset edge.

## Timing
- Reset values: TX=1, BUSY=0, CONSOLE_OUT_ready=1.
- Start-bit latency from IDLE with an empty FIFO:
  - Byte accepted at edge k, FIFO count becomes 1.
  - Pop and transition to START at edge k+1. TX=0 from edge k+1.
- Frame length: exactly 10*CLK_DIV cycles, start edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge that ends the previous stop bit.
- CONSOLE_OUT_ready rises on the edge after the pop that makes the FIFO non-full.
- BUSY falls on the edge where STOP ends with an empty FIFO.

## Test plan
All scenarios use CLK_DIV=10 and FIFO_DEPTH=4.

- **Reset:** assert RESET for 2 cycles → TX=1, CONSOLE_OUT_ready=1, BUSY=0. Hold idle for 50 cycles → TX stays 1.
- **Single byte:** send 0x41 with valid high for one accepted cycle at edge k.
  - TX=0 for 10 cycles starting at edge k+1.
  - Data bits 1,0,0,0,0,0,1,0, 10 cycles each, then stop bit 1 for 10 cycles.
  - BUSY=0 at edge k+101.
- **Burst with backpressure:** hold valid with bytes 0x30..0x35.
  - Five bytes are accepted on five consecutive edges (the first pop frees a slot), then ready=0.
  - 0x35 is accepted on the edge after the pop of 0x31.
  - TX carries six gap-free frames (600 cycles) in order 0x30..0x35.
- **Stall hold:** while ready=0, change CONSOLE_OUT every cycle with valid=1 → no byte is written and FIFO contents are unchanged. Only the value present on the accepting edge is transmitted.
- **Reset mid-frame:** send 0xFF and 0x00, then assert RESET during data bit 3 of the first frame.
  - TX=1 at the reset edge; ready=1; BUSY=0.
  - 0x00 is never transmitted.
  - A new byte 0x55 sent after reset is transmitted correctly.
- **Pointer wrap:** send 9 single bytes spaced 120 cycles apart (0x01..0x09) → all transmitted in order with correct bits across pointer wrap-around.
